// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the shared-ALU scheduler: operand width defaults,
//   ALU operation codes, FSM state encoding and a small op classifier.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int XLEN_DEFAULT    = 32;
  localparam int SHAMT_W_DEFAULT = 5;

  // Operation codes; 8..15 are illegal.
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_SLL = 4'd4;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // True for the iterative (one bit per cycle) operations.
  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// -----------------------------------------------------------------------------
// alu_rr_arb2
//   Two-way round-robin arbiter. On a tie the port that did not win the last
//   accepted grant wins. The history only advances when the grant is actually
//   used, so a requester dropping valid before acceptance does not shift
//   priority.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req[1:0]    request vector (bit N = port N valid)
//   accept      the current grant is taken this cycle
//   gnt_id      granted port index (meaningful when req != 0)
// -----------------------------------------------------------------------------
module alu_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       gnt_id
);

  // Resets to 1 so port 0 wins the first tie.
  logic last_gnt;

  always_comb begin
    case (req)
      2'b11:   gnt_id = ~last_gnt;
      2'b10:   gnt_id = 1'b1;
      default: gnt_id = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_gnt <= 1'b1;
    else if (accept) last_gnt <= gnt_id;
  end

endmodule

// File: rtl/alu_share_sched.sv
// -----------------------------------------------------------------------------
// alu_share_sched
//   Shares one multi-cycle ALU between two requesters with valid/ready
//   handshakes and round-robin arbitration. Logic/arithmetic ops finish in the
//   accept cycle; shifts iterate one bit per cycle.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready           request handshake, port N (0: EX issue, 1: helper)
//   reqN_op/a/b                op code, operand A, operand B / shift amount
//   resp_valid/ready           response handshake
//   resp_id                    port that issued the response
//   resp_result                result (0 for illegal ops)
//   resp_illegal               op code was not supported
//   busy                       FSM not idle
// -----------------------------------------------------------------------------
module alu_share_sched
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int SHAMT_W = SHAMT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [XLEN-1:0] resp_result,
  output logic            resp_illegal,
  output logic            busy
);

  state_t               state_q, state_d;
  logic [XLEN-1:0]      acc_q;
  logic [SHAMT_W-1:0]   cnt_q;
  logic [3:0]           op_q;
  logic                 id_q;
  logic                 illegal_q;

  logic                 gnt_id;
  logic                 accept;
  logic [3:0]           sel_op;
  logic [XLEN-1:0]      sel_a, sel_b;
  logic [SHAMT_W-1:0]   sel_shamt;
  logic                 sel_shift;

  // Single-cycle operations; shifts and illegal codes yield 0 here.
  function automatic logic [XLEN-1:0] alu_single(input logic [3:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_XOR: return a ^ b;
      ALU_SUB: return a - b;
      default: return '0;
    endcase
  endfunction

  // One iteration of the bit-serial shifter.
  function automatic logic [XLEN-1:0] shift_one(input logic [3:0] op,
                                                input logic [XLEN-1:0] v);
    case (op)
      ALU_SLL: return {v[XLEN-2:0], 1'b0};
      ALU_SRL: return {1'b0, v[XLEN-1:1]};
      ALU_SRA: return {v[XLEN-1], v[XLEN-1:1]};
      default: return v;
    endcase
  endfunction

  alu_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1_valid, req0_valid}),
    .accept (accept),
    .gnt_id (gnt_id)
  );

  // rst_n gates acceptance so ready stays low while reset is held, even with
  // requests pending and the FSM already forced to IDLE.
  assign accept    = rst_n && (state_q == ST_IDLE) && (req0_valid || req1_valid);
  assign sel_op    = gnt_id ? req1_op : req0_op;
  assign sel_a     = gnt_id ? req1_a  : req0_a;
  assign sel_b     = gnt_id ? req1_b  : req0_b;
  assign sel_shamt = sel_b[SHAMT_W-1:0];
  assign sel_shift = is_shift(sel_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          if (sel_shift && (sel_shamt != '0)) state_d = ST_SHIFT;
          else                                state_d = ST_DONE;
        end
      end
      ST_SHIFT: begin
        // The shift on this edge takes cnt to zero, so the result is final.
        if (cnt_q == SHAMT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latch at accept, then bit-serial iteration in SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      id_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      id_q      <= gnt_id;
      op_q      <= sel_op;
      illegal_q <= sel_op[3];
      if (sel_shift) begin
        acc_q <= sel_a;
        cnt_q <= sel_shamt;
      end else begin
        acc_q <= alu_single(sel_op, sel_a, sel_b);
        cnt_q <= '0;
      end
    end else if (state_q == ST_SHIFT) begin
      acc_q <= shift_one(op_q, acc_q);
      cnt_q <= cnt_q - SHAMT_W'(1);
    end
  end

  assign resp_valid   = (state_q == ST_DONE);
  assign resp_id      = id_q;
  assign resp_result  = acc_q;
  assign resp_illegal = illegal_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_sched.sv
module tb_alu_share_sched;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [3:0]  req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [3:0]  req1_op;
  logic [31:0] req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id, resp_illegal, busy;
  logic [31:0] resp_result;

  int n_vec = 0;
  int n_err = 0;

  alu_share_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_op      (req0_op),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_op      (req1_op),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_result  (resp_result),
    .resp_illegal (resp_illegal),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request at a negedge, waits for its acceptance, and measures
  // cycles from the accept edge to resp_valid (1 = the cycle right after).
  // Returns at the negedge where resp_valid is first seen; lat=-1 on timeout.
  task automatic run_op(input logic p, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res,
                        output logic id, output logic ill, output logic bz);
    int w;
    if (p) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    #1;
    w = 0;
    while (!(p ? req1_ready : req0_ready) && w < 20) begin
      @(negedge clk); #1; w++;
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1;
    bz  = 1'b1;
    while (!resp_valid && lat < 100) begin
      bz &= busy;
      @(negedge clk);
      lat++;
    end
    bz &= busy;
    if (!resp_valid || w >= 20) lat = -1;
    res = resp_result;
    id  = resp_id;
    ill = resp_illegal;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op = ALU_ADD; req0_a = 32'd1; req0_b = 32'd1;
    req1_op = ALU_ADD; req1_a = 32'd2; req1_b = 32'd2;
    resp_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    n_vec++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL rst_req0_ready got %b exp 0", req0_ready); end
    n_vec++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL rst_req1_ready got %b exp 0", req1_ready); end
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
    n_vec++; if (resp_id !== 1'b0) begin n_err++; $display("FAIL rst_resp_id got %b exp 0", resp_id); end
    n_vec++; if (resp_result !== 32'h0) begin n_err++; $display("FAIL rst_resp_result got %h exp 0", resp_result); end
    n_vec++; if (resp_illegal !== 1'b0) begin n_err++; $display("FAIL rst_resp_illegal got %b exp 0", resp_illegal); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_cycle_ops;
    int lat; logic [31:0] res; logic id, ill, bz;
    logic        tp  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0]  top [4] = '{ALU_ADD, ALU_AND, ALU_OR, ALU_XOR};
    logic [31:0] ta  [4] = '{32'hFFFF_FFFF, 32'h0000_F0F0, 32'h0000_000F, 32'h0000_AAAA};
    logic [31:0] tb  [4] = '{32'h0000_0001, 32'h0000_FF00, 32'h0000_00F0, 32'h0000_FFFF};
    logic [31:0] te  [4] = '{32'h0000_0000, 32'h0000_F000, 32'h0000_00FF, 32'h0000_5555};
    for (int i = 0; i < 4; i++) begin
      resp_ready = 1'b1;
      run_op(tp[i], top[i], ta[i], tb[i], lat, res, id, ill, bz);
      n_vec++; if (lat != 1) begin n_err++; $display("FAIL op%0d_latency got %0d exp 1", i, lat); end
      n_vec++; if (res !== te[i]) begin n_err++; $display("FAIL op%0d_result got %h exp %h", i, res, te[i]); end
      n_vec++; if (id !== tp[i]) begin n_err++; $display("FAIL op%0d_id got %b exp %b", i, id, tp[i]); end
      n_vec++; if (ill !== 1'b0) begin n_err++; $display("FAIL op%0d_illegal got %b exp 0", i, ill); end
      @(negedge clk);
    end
  endtask

  task automatic test_arbitration;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1'b1; req1_op = ALU_XOR; req1_a = 32'd5; req1_b = 32'd3;
    #1;
    n_vec++; if ({req1_ready, req0_ready} !== 2'b01) begin n_err++; $display("FAIL tie1_ready got %b exp 01", {req1_ready, req0_ready}); end
    @(negedge clk); #1;
    n_vec++; if ({resp_valid, resp_id, resp_result} !== {1'b1, 1'b0, 32'd3}) begin n_err++; $display("FAIL tie1_resp got v%b id%b %h exp v1 id0 3", resp_valid, resp_id, resp_result); end
    @(negedge clk); #1;
    n_vec++; if ({req1_ready, req0_ready} !== 2'b10) begin n_err++; $display("FAIL tie2_ready got %b exp 10", {req1_ready, req0_ready}); end
    @(negedge clk); #1;
    n_vec++; if ({resp_valid, resp_id, resp_result} !== {1'b1, 1'b1, 32'd6}) begin n_err++; $display("FAIL tie2_resp got v%b id%b %h exp v1 id1 6", resp_valid, resp_id, resp_result); end
    @(negedge clk); #1;
    n_vec++; if ({req1_ready, req0_ready} !== 2'b01) begin n_err++; $display("FAIL tie3_ready got %b exp 01", {req1_ready, req0_ready}); end
    // Withdraw before the edge: nothing may be accepted.
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); #1;
    n_vec++; if ({busy, resp_valid} !== 2'b00) begin n_err++; $display("FAIL withdraw got busy%b v%b exp 00", busy, resp_valid); end
    @(negedge clk);
  endtask

  task automatic test_shifts;
    int lat; logic [31:0] res; logic id, ill, bz;
    logic        tp  [3] = '{1'b1, 1'b0, 1'b0};
    logic [3:0]  top [3] = '{ALU_SRA, ALU_SLL, ALU_SRL};
    logic [31:0] ta  [3] = '{32'h8000_0000, 32'h0000_0001, 32'h0000_00F0};
    logic [31:0] tb  [3] = '{32'h0000_001F, 32'h0000_0003, 32'h0000_0004};
    logic [31:0] te  [3] = '{32'hFFFF_FFFF, 32'h0000_0008, 32'h0000_000F};
    int          tl  [3] = '{32, 4, 5};
    for (int i = 0; i < 3; i++) begin
      resp_ready = 1'b1;
      run_op(tp[i], top[i], ta[i], tb[i], lat, res, id, ill, bz);
      n_vec++; if (lat != tl[i]) begin n_err++; $display("FAIL sh%0d_latency got %0d exp %0d", i, lat, tl[i]); end
      n_vec++; if (res !== te[i]) begin n_err++; $display("FAIL sh%0d_result got %h exp %h", i, res, te[i]); end
      n_vec++; if (id !== tp[i]) begin n_err++; $display("FAIL sh%0d_id got %b exp %b", i, id, tp[i]); end
      n_vec++; if (bz !== 1'b1) begin n_err++; $display("FAIL sh%0d_busy got %b exp 1", i, bz); end
      @(negedge clk);
    end
  endtask

  task automatic test_shamt_zero_and_sub;
    int lat; logic [31:0] res; logic id, ill, bz;
    resp_ready = 1'b1;
    run_op(1'b0, ALU_SLL, 32'h1, 32'h20, lat, res, id, ill, bz);
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL sll0_latency got %0d exp 1", lat); end
    n_vec++; if (res !== 32'h1) begin n_err++; $display("FAIL sll0_result got %h exp 00000001", res); end
    @(negedge clk);
    run_op(1'b1, ALU_SUB, 32'd3, 32'd5, lat, res, id, ill, bz);
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL sub_latency got %0d exp 1", lat); end
    n_vec++; if (res !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sub_result got %h exp fffffffe", res); end
    @(negedge clk);
  endtask

  task automatic test_illegal_hold;
    int lat; logic [31:0] res; logic id, ill, bz;
    resp_ready = 1'b0;
    run_op(1'b0, 4'd9, 32'h1234, 32'h1, lat, res, id, ill, bz);
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL ill_latency got %0d exp 1", lat); end
    n_vec++; if (ill !== 1'b1) begin n_err++; $display("FAIL ill_flag got %b exp 1", ill); end
    n_vec++; if (res !== 32'h0) begin n_err++; $display("FAIL ill_result got %h exp 0", res); end
    req0_valid = 1'b1; req0_op = ALU_ADD;
    req1_valid = 1'b1; req1_op = ALU_ADD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_vec++;
      if ({resp_valid, resp_illegal, resp_id, resp_result, req0_ready, req1_ready} !== {3'b110, 32'h0, 2'b00}) begin
        n_err++;
        $display("FAIL hold%0d got v%b ill%b id%b %h r0%b r1%b exp v1 ill1 id0 0 r00 r10",
                 i, resp_valid, resp_illegal, resp_id, resp_result, req0_ready, req1_ready);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk); #1;
    n_vec++; if ({resp_valid, busy} !== 2'b00) begin n_err++; $display("FAIL ill_release got v%b busy%b exp 00", resp_valid, busy); end
  endtask

  task automatic test_reset_mid_shift;
    resp_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = ALU_SLL; req0_a = 32'h1; req0_b = 32'd20;
    #1;
    n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL mid_accept got %b exp 1", req0_ready); end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (10) @(negedge clk);
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd7; req0_b = 32'd8;
    req1_valid = 1'b1; req1_op = ALU_OR;  req1_a = 32'h0; req1_b = 32'h0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got %b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({req0_ready, req1_ready, resp_valid, resp_id, resp_illegal, busy, resp_result} !== {6'b0, 32'h0}) begin
      n_err++;
      $display("FAIL mid_reset got r0%b r1%b v%b id%b ill%b busy%b %h exp all 0",
               req0_ready, req1_ready, resp_valid, resp_id, resp_illegal, busy, resp_result);
    end
    @(negedge clk); @(negedge clk); #1;
    n_vec++; if ({resp_valid, busy} !== 2'b00) begin n_err++; $display("FAIL mid_held got v%b busy%b exp 00", resp_valid, busy); end
    rst_n = 1'b1;
    #1;
    n_vec++; if ({req1_ready, req0_ready} !== 2'b01) begin n_err++; $display("FAIL post_rst_tie got %b exp 01", {req1_ready, req0_ready}); end
    @(negedge clk); #1;
    n_vec++;
    if ({resp_valid, resp_id, resp_result} !== {1'b1, 1'b0, 32'd15}) begin
      n_err++;
      $display("FAIL post_rst_resp got v%b id%b %h exp v1 id0 0000000f", resp_valid, resp_id, resp_result);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_single_cycle_ops;
    test_arbitration;
    test_shifts;
    test_shamt_zero_and_sub;
    test_illegal_hold;
    test_reset_mid_shift;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
